// File: rtl/fpu_stack_responder.sv
// Register-stack responder for the microsequencer: eight FP80 registers, TOP pointer and tags.
// Optional stack-fault detection is enabled by defining FPU_STACK_FAULT_EN.
module fpu_stack_responder #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [79:0] INDEFINITE = 80'hFFFF_C000000000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stack_push_req,
  input  logic        stack_pop_req,
  input  logic        stack_write_en,
  input  logic [2:0]  stack_write_sel,
  input  logic [79:0] stack_write_data,
  input  logic [2:0]  stack_read_sel,
  output logic [79:0] stack_read_data,
  output logic        stack_op_done,
  output logic [2:0]  stack_top,
  output logic [15:0] tag_word,
  input  logic        fault_clear,
  output logic        stack_fault,
  output logic        stack_c1
);

  localparam int N = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  state_t      state, state_next;
  logic [79:0] regs [N];
  logic [1:0]  tags [N];
  logic [2:0]  top;
  logic        go, do_push, do_pop, push_fault;
  logic [2:0]  push_top, pop_top, wr_idx, rd_idx;

  assign go       = (state == IDLE) && (stack_push_req || stack_pop_req || stack_write_en);
  assign do_push  = stack_push_req && !stack_pop_req;
  assign do_pop   = stack_pop_req && !stack_push_req;
  assign push_top = top - 3'd1;
  assign pop_top  = top + 3'd1;
  assign wr_idx   = top + stack_write_sel;
  assign rd_idx   = top + stack_read_sel;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (go) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop+write applies the write first, so a pop of the written slot still empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      top   <= 3'd0;
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
        tags[i] <= 2'b11;
      end
    end else begin
      state <= state_next;
      if (go) begin
        if (do_push) begin
          top            <= push_top;
          tags[push_top] <= 2'b00;
          if (push_fault)
            regs[push_top] <= INDEFINITE;
          else if (stack_write_en)
            regs[push_top] <= stack_write_data;
        end else begin
          if (stack_write_en) begin
            regs[wr_idx] <= stack_write_data;
            tags[wr_idx] <= 2'b00;
          end
          if (do_pop) begin
            tags[top] <= 2'b11;
            top       <= pop_top;
          end
        end
      end
    end
  end

`ifdef FPU_STACK_FAULT_EN
  logic pop_fault, sf_q, c1_q;

  assign push_fault = go && do_push && (tags[push_top] != 2'b11);
  assign pop_fault  = go && do_pop && (tags[top] == 2'b11) &&
                      !(stack_write_en && (stack_write_sel == 3'd0));

  // A fault in the same cycle as fault_clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      sf_q <= 1'b0;
      c1_q <= 1'b0;
    end else if (push_fault || pop_fault) begin
      sf_q <= 1'b1;
      c1_q <= push_fault;
    end else if (fault_clear) begin
      sf_q <= 1'b0;
      c1_q <= 1'b0;
    end
  end

  assign stack_fault     = sf_q;
  assign stack_c1        = c1_q;
  assign stack_read_data = (tags[rd_idx] == 2'b11) ? INDEFINITE : regs[rd_idx];
`else
  logic unused_fault_clear;

  assign unused_fault_clear = fault_clear;
  assign push_fault         = 1'b0;
  assign stack_fault        = 1'b0;
  assign stack_c1           = 1'b0;
  assign stack_read_data    = regs[rd_idx];
`endif

  always_comb begin
    tag_word = '0;
    for (int i = 0; i < 8; i++)
      tag_word[2*i +: 2] = tags[i];
  end

  assign stack_top     = top;
  assign stack_op_done = (state == DONE) && !reset;

endmodule

// File: tb/tb_fpu_stack_responder.sv
// Randomized self-checking bench for fpu_stack_responder against a stack-level reference model.
module tb_fpu_stack_responder;

  localparam logic [79:0] INDEF = 80'hFFFF_C000000000000000;
`ifdef FPU_STACK_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stack_push_req = 1'b0;
  logic        stack_pop_req = 1'b0;
  logic        stack_write_en = 1'b0;
  logic [2:0]  stack_write_sel = 3'd0;
  logic [79:0] stack_write_data = '0;
  logic [2:0]  stack_read_sel = 3'd0;
  logic [79:0] stack_read_data;
  logic        stack_op_done;
  logic [2:0]  stack_top;
  logic [15:0] tag_word;
  logic        fault_clear = 1'b0;
  logic        stack_fault;
  logic        stack_c1;

  fpu_stack_responder dut (
    .clk(clk), .reset(reset),
    .stack_push_req(stack_push_req), .stack_pop_req(stack_pop_req),
    .stack_write_en(stack_write_en), .stack_write_sel(stack_write_sel),
    .stack_write_data(stack_write_data), .stack_read_sel(stack_read_sel),
    .stack_read_data(stack_read_data), .stack_op_done(stack_op_done),
    .stack_top(stack_top), .tag_word(tag_word), .fault_clear(fault_clear),
    .stack_fault(stack_fault), .stack_c1(stack_c1)
  );

  always #10 clk = ~clk;

  // Reference model: the stack as an array of values plus an empty flag per slot.
  logic [79:0] m_reg [8];
  bit          m_empty [8];
  logic [2:0]  m_top;
  bit          m_sf, m_c1;
  int          total = 0;
  int          bad = 0;

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]   = '0;
      m_empty[i] = 1'b1;
    end
    m_top = 3'd0;
    m_sf  = 1'b0;
    m_c1  = 1'b0;
  endtask

  task automatic modelOp(input bit push, input bit pop, input bit we, input logic [2:0] sel,
                         input logic [79:0] data, input bit fclr);
    bit         fault = 1'b0;
    bit         ovf = 1'b0;
    logic [2:0] slot;
    if (push && !pop) begin
      slot = m_top - 3'd1;
      if (FAULT_EN && !m_empty[slot]) begin
        fault = 1'b1;
        ovf   = 1'b1;
        m_reg[slot] = INDEF;
      end else if (we) begin
        m_reg[slot] = data;
      end
      m_empty[slot] = 1'b0;
      m_top = slot;
    end else begin
      if (we) begin
        slot = m_top + sel;
        m_reg[slot]   = data;
        m_empty[slot] = 1'b0;
      end
      if (pop && !push) begin
        if (FAULT_EN && m_empty[m_top]) fault = 1'b1;
        m_empty[m_top] = 1'b1;
        m_top = m_top + 3'd1;
      end
    end
    if (fault) begin
      m_sf = 1'b1;
      m_c1 = ovf;
    end else if (fclr) begin
      m_sf = 1'b0;
      m_c1 = 1'b0;
    end
  endtask

  task automatic checkState();
    logic [15:0] exp_tags;
    logic [2:0]  slot;
    for (int i = 0; i < 8; i++) begin
      stack_read_sel = 3'(i);
      #1;
      slot = m_top + 3'(i);
      checkOutput("read", stack_read_data, (FAULT_EN && m_empty[slot]) ? INDEF : m_reg[slot]);
    end
    exp_tags = '0;
    for (int i = 0; i < 8; i++) exp_tags[2*i +: 2] = m_empty[i] ? 2'b11 : 2'b00;
    checkOutput("top", 80'(stack_top), 80'(m_top));
    checkOutput("tag_word", 80'(tag_word), 80'(exp_tags));
    checkOutput("sf", 80'(stack_fault), 80'(m_sf));
    checkOutput("c1", 80'(stack_c1), 80'(m_c1));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("done_reset", 80'(stack_op_done), 80'd0);
    checkState();
  endtask

  task automatic applyStimulus(input bit push, input bit pop, input bit we, input logic [2:0] sel,
                               input logic [79:0] data, input bit fclr);
    @(negedge clk);
    stack_push_req   = push;
    stack_pop_req    = pop;
    stack_write_en   = we;
    stack_write_sel  = sel;
    stack_write_data = data;
    fault_clear      = fclr;
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 80'(stack_op_done), 80'd1);
    modelOp(push, pop, we, sel, data, fclr);
    stack_push_req = 1'b0;
    stack_pop_req  = 1'b0;
    stack_write_en = 1'b0;
    fault_clear    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done_low", 80'(stack_op_done), 80'd0);
    checkState();
  endtask

  task automatic idleCycle(input bit fclr);
    @(negedge clk);
    fault_clear = fclr;
    @(posedge clk);
    #1;
    fault_clear = 1'b0;
    if (fclr) begin
      m_sf = 1'b0;
      m_c1 = 1'b0;
    end
    checkOutput("idle_done", 80'(stack_op_done), 80'd0);
    checkState();
  endtask

  function automatic logic [79:0] randData();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  initial begin
    logic [79:0] d;
    bit p, q, w;

    doReset();
    checkOutput("reset_tags", 80'(tag_word), 80'(16'hFFFF));

    applyStimulus(1, 0, 1, 3'd5, 80'h3FFF8000000000000000, 0);
    checkOutput("first_tags", 80'(tag_word), 80'(16'h3FFF));
    checkOutput("first_top", 80'(stack_top), 80'd7);

    applyStimulus(1, 0, 1, 3'd0, 80'hAAAA, 0);
    applyStimulus(1, 0, 1, 3'd0, 80'hBBBB, 0);
    applyStimulus(1, 0, 1, 3'd0, 80'hCCCC, 0);
    applyStimulus(0, 1, 1, 3'd1, 80'hDDDD, 0);
    applyStimulus(0, 1, 1, 3'd0, 80'hEEEE, 0);
    applyStimulus(0, 0, 1, 3'd3, 80'h1234, 0);

    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 3'd0, 80'(i + 16), 0);
    checkOutput("full_tags", 80'(tag_word), 80'd0);
    applyStimulus(1, 0, 1, 3'd0, 80'h5555, 0);
    idleCycle(1);

    doReset();
    applyStimulus(0, 1, 0, 3'd0, '0, 0);
    idleCycle(1);
    applyStimulus(0, 1, 0, 3'd0, '0, 1);
    applyStimulus(1, 1, 1, 3'd2, 80'h7777, 0);

    // Held push request: two operations in four cycles.
    doReset();
    @(negedge clk);
    stack_push_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_done", 80'(stack_op_done), (k % 2 == 0) ? 80'd1 : 80'd0);
    end
    stack_push_req = 1'b0;
    modelOp(1, 0, 0, 3'd0, '0, 0);
    modelOp(1, 0, 0, 3'd0, '0, 0);
    checkState();

    // Reset during the DONE cycle.
    @(negedge clk);
    stack_push_req   = 1'b1;
    stack_write_en   = 1'b1;
    stack_write_data = 80'h9999;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_done", 80'(stack_op_done), 80'd1);
    stack_push_req = 1'b0;
    stack_write_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_in_done", 80'(stack_op_done), 80'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput("after_reset_done", 80'(stack_op_done), 80'd0);
    checkState();
    checkOutput("after_reset_tags", 80'(tag_word), 80'(16'hFFFF));

    doReset();
    for (int n = 0; n < 150; n++) begin
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = randData();
      if (!p && !q && !w)
        idleCycle($urandom_range(0, 3) == 0);
      else
        applyStimulus(p, q, w, 3'($urandom_range(0, 7)), d, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_stack_responder.md
# fpu_stack_responder

Responder end of the microsequencer's register-stack interface: accepts push, pop, and write requests from `MicroSequencer_Extended` and answers them with a registered `stack_op_done` pulse. It also serves combinational reads of ST(i). It holds the eight 80-bit FP registers, the 3-bit TOP pointer, and a 2-bit tag per physical register. It sits beside `FPU_ArithmeticUnit` in the FPU core and replaces the constant tie-offs (`stack_read_data=0`, `stack_op_done=1`) used in microcode unit benches.

## Interface
Parameters:
- `DEPTH_LOG2`, 3: log2 of register count; only 3 is supported.
- `INDEFINITE`, 80'hFFFF_C000000000000000: QNaN indefinite value written or returned on stack faults.

Ports:
- `clk`  in  1  system clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stack_push_req`  in  1  push request; level, held by the requester until `stack_op_done`.
- `stack_pop_req`  in  1  pop request; level, held until `stack_op_done`.
- `stack_write_en`  in  1  write request; level, held until `stack_op_done`.
- `stack_write_sel`  in  3  ST(i) index for the write, relative to TOP.
- `stack_write_data`  in  80  FP80 write data.
- `stack_read_sel`  in  3  ST(i) index for the combinational read.
- `stack_read_data`  out  80  contents of physical register (TOP+`stack_read_sel`) mod 8.
- `stack_op_done`  out  1  one-cycle completion pulse.
- `stack_top`  out  3  current TOP pointer.
- `tag_word`  out  16  tags, 2 bits per physical register, register 0 in [1:0]; 00 = valid, 11 = empty.
- `fault_clear`  in  1  clears `stack_fault` and `stack_c1`.
- `stack_fault`  out  1  sticky stack-fault flag (SF).
- `stack_c1`  out  1  fault direction: 1 = overflow, 0 = underflow.

## Operation
FSM has two states:
- IDLE
  - If any of push, pop, or write_en is high: execute the operation this edge, go to DONE.
  - Otherwise stay in IDLE.
- DONE
  - `stack_op_done`=1 for exactly this cycle.
  - All requests are ignored.
  - Always returns to IDLE.

Operations (P = physical index, all arithmetic mod 8):
- Push only: TOP←TOP−1; tag[new TOP]←00.
- Push + write_en: as push, then reg[new TOP]←`stack_write_data`; `stack_write_sel` is ignored.
- Pop only: tag[TOP]←11; TOP←TOP+1.
- Pop + write_en: reg[old TOP+`stack_write_sel`]←data and its tag←00 first, then the pop. If the write target equals old TOP, the pop still empties it.
- Write_en only: reg[TOP+sel]←data; tag←00.
- Push + pop together: TOP and tags unchanged; write_en (if set) is applied relative to the current TOP; `stack_op_done` still pulses.

Other rules:
- `stack_read_data` is combinational and always valid; there is no handshake for reads.
- TOP wraps modulo 8 in both directions.
- `fault_clear` clears SF and C1 in any state. A fault occurring in the same cycle wins: SF=1 and C1 is set by the new fault.

## Timing
Reset values:
- state IDLE, TOP=0, `tag_word`=16'hFFFF.
- all registers 0.
- `stack_op_done`=0, `stack_fault`=0, `stack_c1`=0.

Latency and handshake:
- Request high in IDLE at edge E → state, TOP, tags, and registers update at E → `stack_op_done`=1 during the cycle E..E+1.
- The requester must drop its request at E+1, the edge at which it samples done.
- A request still high in IDLE after DONE is treated as a new operation.
- Back-to-back operations complete one every 2 cycles.

Reset mid-operation: reset during DONE forces IDLE with no done pulse; the state updated at E is discarded back to reset values.

## Configuration
`FPU_STACK_FAULT_EN`:
- Defined:
  - Push onto a non-empty target register → SF=1, C1=1; the register is loaded with INDEFINITE (push data discarded); TOP still decrements.
  - Pop of an empty TOP → SF=1, C1=0; TOP still increments.
  - A read of an empty register returns INDEFINITE.
- Undefined:
  - No fault detection; `stack_fault` and `stack_c1` are tied to 0.
  - Push overwrites with data; reads return raw contents.
  - Tags are still maintained.

## Test plan
- Reset, then push+write 0x3FFF8000000000000000 → done pulses 1 cycle after the request edge; TOP=7; `tag_word`=16'h3FFF; read_sel=0 returns 0x3FFF8000…; state returns to IDLE.
- Push three values A, B, C then read_sel 0/1/2 → C, B, A. Pop+write_en with sel=1 and data D → TOP=6; ST(0)=D; `tag_word`[11:10]=11.
- Eight pushes from reset → TOP wraps 7…0; all tags 00; no fault. A ninth push → SF=1, C1=1; reg[7]=INDEFINITE when `FPU_STACK_FAULT_EN` is defined, or the data value when it is undefined.
- Pop from reset → TOP=1; with the macro: SF=1, C1=0, and read_sel=0 gives INDEFINITE. Asserting `fault_clear` clears both next edge; `fault_clear` coincident with a new fault leaves SF=1.
- Hold push high for 4 cycles from IDLE → exactly 2 pushes (done pulses at cycles 1 and 3); push+pop together → TOP unchanged, done pulses.
- Reset asserted during DONE → no done pulse; TOP=0; `tag_word`=16'hFFFF.
